// File: rtl/vm80_intc_pkg.sv
// rtl/vm80_intc_pkg.sv - shared constants, types and priority helper for vm80_intc
//
// Purpose: opcode/vector constants, register offsets and the lowest-set-bit
// priority function used by the resolver.

package vm80_intc_pkg;

    // RST n opcode is 0xC7 with n in bits 5:3.
    localparam logic [7:0] RST_OPC_BASE = 8'hC7;
    // Spurious acknowledge returns RST 7.
    localparam logic [7:0] SPURIOUS_VEC = 8'hFF;

    // Register offsets selected by a0.
    localparam logic REG_MASK = 1'b0;
    localparam logic REG_PEND = 1'b1;

    typedef struct packed {
        logic       valid;
        logic [2:0] idx;
    } prio_t;

    // Lowest set bit wins (bit 0 is the highest priority line).
    function automatic prio_t prio_lowest(input logic [7:0] v);
        prio_t r;
        r.valid = 1'b0;
        r.idx   = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) begin
                r.valid = 1'b1;
                r.idx   = 3'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/vm80_intc_if.sv
// rtl/vm80_intc_if.sv - vm80a bus/interrupt signal bundle for vm80_intc
//
// Purpose: groups the CPU status/strobe signals, register select and the
// controller's outputs.
//   irq[7:0]      raw request lines (bit 0 highest priority)
//   cpu_sync      CPU status strobe
//   cpu_dout[7:0] CPU data out; bit 0 during sync is the INTA status bit
//   cpu_dbin      CPU read strobe
//   cpu_wr_n      CPU write strobe, active low
//   cs, a0        register select and offset
//   intr          interrupt request to CPU
//   inta          current machine cycle is interrupt acknowledge
//   dout[7:0]     read data / RST vector

interface vm80_intc_if;
    import vm80_intc_pkg::*;

    logic [7:0] irq;
    logic       cpu_sync;
    logic [7:0] cpu_dout;
    logic       cpu_dbin;
    logic       cpu_wr_n;
    logic       cs;
    logic       a0;
    logic       intr;
    logic       inta;
    logic [7:0] dout;

    modport master (
        output irq, cpu_sync, cpu_dout, cpu_dbin, cpu_wr_n, cs, a0,
        input  intr, inta, dout
    );

    modport slave (
        input  irq, cpu_sync, cpu_dout, cpu_dbin, cpu_wr_n, cs, a0,
        output intr, inta, dout
    );

endinterface

// File: rtl/vm80_intc_prio.sv
// rtl/vm80_intc_prio.sv - combinational priority resolver for vm80_intc
//
// Purpose: picks the highest-priority pending, unmasked line that outranks
// every in-service line.
//   i_pending[7:0]  effective pending lines
//   i_mask[7:0]     mask register (1 = masked)
//   i_isr[7:0]      in-service register
//   o_elig_any      at least one line is eligible
//   o_win[2:0]      index of the winning line (valid when o_elig_any)

module vm80_intc_prio (
    input  logic [7:0] i_pending,
    input  logic [7:0] i_mask,
    input  logic [7:0] i_isr,
    output logic       o_elig_any,
    output logic [2:0] o_win
);
    import vm80_intc_pkg::*;

    prio_t      w_isr_lo;
    prio_t      w_sel;
    logic [7:0] w_higher;
    logic [7:0] w_elig;

    // Only lines strictly above the highest-priority in-service line may nest.
    assign w_isr_lo = prio_lowest(i_isr);
    assign w_higher = w_isr_lo.valid ? ((8'h01 << w_isr_lo.idx) - 8'h01) : 8'hFF;
    assign w_elig   = i_pending & ~i_mask & w_higher;
    assign w_sel    = prio_lowest(w_elig);

    assign o_elig_any = w_sel.valid;
    assign o_win      = w_sel.idx;

endmodule

// File: rtl/vm80_intc.sv
// rtl/vm80_intc.sv - 8-input vectored interrupt controller for the vm80a bus
//
// Purpose: synchronises and senses request lines, raises intr, commits the
// winning line on the INTA status cycle and returns an RST n opcode; exposes
// mask and pending/EOI registers.
//   pin_clk    system clock
//   pin_reset  asynchronous active-high reset
//   bus        vm80_intc_if.slave (request lines, CPU strobes, intr/inta/dout)

module vm80_intc #(
    parameter logic [7:0] EDGE_MASK = 8'hFF,
    parameter logic [7:0] RST_MASK  = 8'hFF
) (
    input  logic         pin_clk,
    input  logic         pin_reset,
    vm80_intc_if.slave   bus
);
    import vm80_intc_pkg::*;

    logic [7:0] r_s1;
    logic [7:0] r_s2;
    logic [7:0] r_s3;
    logic [7:0] r_pend_edge;
    logic [7:0] r_mask;
    logic [7:0] r_isr;
    logic       r_sync_d;
    logic       r_inta;
    logic       r_intr;
    logic [2:0] r_win;

    logic [7:0] w_pending;
    logic [7:0] w_rise;
    logic       w_status;
    logic       w_elig_any;
    logic [2:0] w_win;
    logic       w_ack;
    logic [7:0] w_ack_bit;
    logic       w_wr;
    logic [7:0] w_eoi;
    logic [7:0] w_dout;

    // Level lines read the synchroniser directly; edge lines use the latch.
    assign w_pending = (r_pend_edge & EDGE_MASK) | (r_s2 & ~EDGE_MASK);
    assign w_rise    = r_s2 & ~r_s3 & EDGE_MASK;

    // First clock of sync only, so a long sync commits once.
    assign w_status  = bus.cpu_sync & ~r_sync_d;
    assign w_ack     = w_status & bus.cpu_dout[0] & w_elig_any;
    assign w_ack_bit = w_ack ? (8'h01 << w_win) : 8'h00;

    assign w_wr  = bus.cs & ~bus.cpu_wr_n;
    assign w_eoi = (w_wr && (bus.a0 == REG_PEND)) ? bus.cpu_dout : 8'h00;

    vm80_intc_prio u_prio (
        .i_pending  (w_pending),
        .i_mask     (r_mask),
        .i_isr      (r_isr),
        .o_elig_any (w_elig_any),
        .o_win      (w_win)
    );

    always_ff @(posedge pin_clk or posedge pin_reset) begin
        if (pin_reset) begin
            r_s1        <= 8'h00;
            r_s2        <= 8'h00;
            r_s3        <= 8'h00;
            r_pend_edge <= 8'h00;
            r_mask      <= RST_MASK;
            r_isr       <= 8'h00;
            r_sync_d    <= 1'b0;
            r_inta      <= 1'b0;
            r_intr      <= 1'b0;
            r_win       <= 3'd0;
        end else begin
            r_s1     <= bus.irq;
            r_s2     <= r_s1;
            r_s3     <= r_s2;
            r_sync_d <= bus.cpu_sync;

            // A new edge beats both the acknowledge clear and the EOI clear.
            r_pend_edge <= ((r_pend_edge & ~(w_ack_bit | w_eoi)) | w_rise) & EDGE_MASK;
            r_isr       <= (r_isr & ~w_eoi) | w_ack_bit;

            if (w_wr && (bus.a0 == REG_MASK)) begin
                r_mask <= bus.cpu_dout;
            end

            r_intr <= w_elig_any & ~r_inta;

            if (w_status) begin
                r_inta <= bus.cpu_dout[0];
                if (bus.cpu_dout[0]) begin
                    r_win <= w_elig_any ? w_win : SPURIOUS_VEC[5:3];
                end
            end
        end
    end

    // Vector has priority over register reads for the whole INTA cycle.
    always_comb begin
        w_dout = 8'h00;
        if (r_inta) begin
            w_dout = RST_OPC_BASE | {2'b00, r_win, 3'b000};
        end else if (bus.cs && bus.cpu_dbin) begin
            w_dout = (bus.a0 == REG_PEND) ? w_pending : r_mask;
        end
    end

    assign bus.intr = r_intr;
    assign bus.inta = r_inta;
    assign bus.dout = w_dout;

endmodule

// File: tb/tb_vm80_intc.sv
// tb/tb_vm80_intc.sv - self-checking bench for vm80_intc

module tb_vm80_intc;

    localparam logic [7:0] EDGE_MASK = 8'hF7;
    localparam logic [7:0] RST_MASK  = 8'hFF;

    logic pin_clk = 1'b0;
    logic pin_reset;

    vm80_intc_if bus();

    vm80_intc #(.EDGE_MASK(EDGE_MASK), .RST_MASK(RST_MASK)) dut (
        .pin_clk   (pin_clk),
        .pin_reset (pin_reset),
        .bus       (bus)
    );

    always #5 pin_clk = ~pin_clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: irq as seen 1/2/3 edges ago, latched edge requests,
    // mask, in-service set, acknowledge state.
    logic [7:0] m_h1, m_h2, m_h3;
    logic [7:0] m_pend, m_mask, m_isr;
    logic       m_inta, m_intr, m_sync_prev;
    int         m_win;

    task automatic model_reset();
        m_h1 = 0; m_h2 = 0; m_h3 = 0;
        m_pend = 0; m_mask = RST_MASK; m_isr = 0;
        m_inta = 0; m_intr = 0; m_sync_prev = 0; m_win = 0;
    endtask

    function automatic logic [7:0] m_pending();
        logic [7:0] p;
        for (int n = 0; n < 8; n++) p[n] = EDGE_MASK[n] ? m_pend[n] : m_h2[n];
        return p;
    endfunction

    // A line may interrupt only if no in-service line has equal or higher priority.
    function automatic bit m_eligible(input int n, input logic [7:0] p);
        if (!p[n] || m_mask[n]) return 1'b0;
        for (int j = 0; j <= n; j++) if (m_isr[j]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [7:0] m_dout();
        if (m_inta) return 8'(199 + 8 * m_win);
        if (bus.cs && bus.cpu_dbin) return bus.a0 ? m_pending() : m_mask;
        return 8'h00;
    endfunction

    task automatic model_edge();
        logic [7:0] p, eoi, rise;
        int first;
        bit nxt_intr;
        p = m_pending();
        first = -1;
        for (int n = 0; n < 8; n++) if (first < 0 && m_eligible(n, p)) first = n;
        nxt_intr = (first >= 0) && !m_inta;
        eoi = (bus.cs && !bus.cpu_wr_n && bus.a0) ? bus.cpu_dout : 8'h00;
        for (int n = 0; n < 8; n++) rise[n] = EDGE_MASK[n] && m_h2[n] && !m_h3[n];
        for (int n = 0; n < 8; n++) begin
            if (eoi[n]) begin
                m_pend[n] = 1'b0;
                m_isr[n]  = 1'b0;
            end
            if (rise[n]) m_pend[n] = 1'b1;
        end
        if (bus.cpu_sync && !m_sync_prev) begin
            m_inta = bus.cpu_dout[0];
            if (bus.cpu_dout[0]) begin
                if (first >= 0) begin
                    m_win = first;
                    m_isr[first] = 1'b1;
                    if (!rise[first]) m_pend[first] = 1'b0;
                end else begin
                    m_win = 7;
                end
            end
        end
        if (bus.cs && !bus.cpu_wr_n && !bus.a0) m_mask = bus.cpu_dout;
        m_intr = nxt_intr;
        m_sync_prev = bus.cpu_sync;
        m_h3 = m_h2; m_h2 = m_h1; m_h1 = bus.irq;
    endtask

    task automatic check_all();
        check_eq("intr", 32'(bus.intr), 32'(m_intr));
        check_eq("inta", 32'(bus.inta), 32'(m_inta));
        check_eq("dout", 32'(bus.dout), 32'(m_dout()));
        check_eq("isr",  32'(dut.r_isr), 32'(m_isr));
    endtask

    task automatic tick();
        @(posedge pin_clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic idle();
        bus.cpu_sync = 0; bus.cpu_dout = 0; bus.cpu_dbin = 0;
        bus.cpu_wr_n = 1; bus.cs = 0; bus.a0 = 0;
    endtask

    task automatic wr_reg(input logic a, input logic [7:0] d);
        bus.cs = 1; bus.a0 = a; bus.cpu_dout = d; bus.cpu_wr_n = 0;
        tick();
        idle();
    endtask

    task automatic rd_reg(input logic a, output logic [7:0] got);
        bus.cs = 1; bus.a0 = a; bus.cpu_dbin = 1;
        tick();
        got = bus.dout;
        idle();
    endtask

    task automatic sync_cyc(input logic [7:0] st, output logic [7:0] vec);
        bus.cpu_sync = 1; bus.cpu_dout = st;
        tick();
        vec = bus.dout;
        idle();
        tick();
    endtask

    task automatic end_inta();
        logic [7:0] v;
        sync_cyc(8'h02, v);
    endtask

    task automatic wait_intr(input int bound);
        for (int i = 0; i < bound && !bus.intr; i++) tick();
        check_eq("wait_intr", 32'(bus.intr), 1);
    endtask

    task automatic do_reset();
        idle();
        pin_reset = 1;
        model_reset();
        #1;
        check_eq("rst_inta", 32'(bus.inta), 0);
        check_eq("rst_intr", 32'(bus.intr), 0);
        check_eq("rst_dout", 32'(bus.dout), 0);
        check_eq("rst_isr",  32'(dut.r_isr), 0);
        check_eq("rst_mask", 32'(dut.r_mask), 32'(RST_MASK));
        @(posedge pin_clk);
        @(posedge pin_clk);
        #2;
        pin_reset = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [7:0] v;
        bus.irq = 0;
        idle();
        pin_reset = 0;
        #2;
        do_reset();
        rd_reg(1'b0, v);
        check_eq("rst_mask_read", 32'(v), 32'hFF);

        // Latency and first acknowledge.
        wr_reg(1'b0, 8'hFE);
        bus.irq = 8'h01;
        tick();
        bus.irq = 8'h00;
        ticks(2);
        check_eq("t1_lat_k2", 32'(bus.intr), 0);
        tick();
        check_eq("t1_lat_k3", 32'(bus.intr), 1);
        sync_cyc(8'h23, v);
        check_eq("t1_vec", 32'(v), 32'hC7);
        check_eq("t1_inta", 32'(bus.inta), 1);
        check_eq("t1_isr", 32'(dut.r_isr), 32'h01);
        check_eq("t1_intr_drop", 32'(bus.intr), 0);
        wr_reg(1'b1, 8'h01);
        end_inta();

        // Two lines together; EOI releases the lower one.
        wr_reg(1'b0, 8'h00);
        bus.irq = 8'h24;
        wait_intr(8);
        sync_cyc(8'h01, v);
        check_eq("t2_vec_a", 32'(v), 32'hD7);
        end_inta();
        ticks(3);
        check_eq("t2_blocked", 32'(bus.intr), 0);
        wr_reg(1'b1, 8'h04);
        wait_intr(6);
        sync_cyc(8'h01, v);
        check_eq("t2_vec_b", 32'(v), 32'hEF);
        wr_reg(1'b1, 8'h20);
        end_inta();
        bus.irq = 8'h00;
        ticks(3);

        // Nesting over RST4.
        bus.irq = 8'h10;
        wait_intr(8);
        sync_cyc(8'h01, v);
        check_eq("t3_vec_4", 32'(v), 32'hE7);
        end_inta();
        bus.irq = 8'h50;
        ticks(5);
        check_eq("t3_lower_blocked", 32'(bus.intr), 0);
        bus.irq = 8'h52;
        wait_intr(8);
        sync_cyc(8'h01, v);
        check_eq("t3_nest_vec", 32'(v), 32'hCF);
        check_eq("t3_isr", 32'(dut.r_isr), 32'h12);
        wr_reg(1'b1, 8'hFF);
        end_inta();
        bus.irq = 8'h00;
        ticks(4);

        // Level-sensed line 3.
        bus.irq = 8'h08;
        wait_intr(8);
        sync_cyc(8'h01, v);
        check_eq("t4_vec", 32'(v), 32'hDF);
        end_inta();
        ticks(4);
        check_eq("t4_no_reack", 32'(bus.intr), 0);
        wr_reg(1'b1, 8'h08);
        wait_intr(4);
        bus.irq = 8'h00;
        ticks(5);

        // Spurious acknowledge after masking.
        bus.irq = 8'h10;
        wait_intr(8);
        wr_reg(1'b0, 8'h10);
        sync_cyc(8'h01, v);
        check_eq("t5_spurious_vec", 32'(v), 32'hFF);
        check_eq("t5_isr", 32'(dut.r_isr), 32'h00);
        end_inta();
        rd_reg(1'b1, v);
        check_eq("t5_pend_read", 32'(v), 32'h10);
        wr_reg(1'b1, 8'h10);
        wr_reg(1'b0, 8'h00);
        bus.irq = 8'h00;
        ticks(3);

        // Long sync commits once; mask write keeps win; reset mid-INTA.
        bus.irq = 8'h06;
        wait_intr(8);
        bus.cpu_sync = 1; bus.cpu_dout = 8'h01;
        ticks(4);
        check_eq("t6_single_commit", 32'(dut.r_isr), 32'h02);
        idle();
        wr_reg(1'b0, 8'hFF);
        check_eq("t6_mask_win", 32'(bus.dout), 32'hCF);
        do_reset();
        bus.irq = 8'h00;
        ticks(3);

        // Randomised traffic against the model.
        for (int it = 0; it < 3000; it++) begin
            for (int n = 0; n < 8; n++) if ($urandom_range(15) == 0) bus.irq[n] = ~bus.irq[n];
            bus.cpu_sync = ($urandom_range(5) == 0);
            bus.cpu_dout = 8'($urandom);
            bus.cs       = ($urandom_range(3) == 0);
            bus.cpu_wr_n = ($urandom_range(2) != 0);
            bus.cpu_dbin = 1'($urandom_range(1));
            bus.a0       = 1'($urandom_range(1));
            tick();
            if (it == 1500) do_reset();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
